dot_scan_controller: RTL and testbench
======================================

Name: dot_scan_controller

Overview:
- Scan engine directly upstream of the dot sequencer. Steps `row_select`/`col_select` through a configured rectangle of the dot matrix and samples the sequencer's `firing_bit`/`firing_data` each step.
- Converts each sampled dot into a timed, registered drive pulse followed by an optional dead-time gap.
- Feeds the motor driver pads and reports scan progress to the host-side control logic.

Parameters:
- MEM_LENGTH, 48: matrix dimension (rows = cols); must match the dot sequencer.
- MEM_ADDRESS_LENGTH, 6: width of row/col indices.
- TIMER_BITS, 16: width of the pulse and gap timers.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; ignored while busy.
- stop  input  1  abort request; has priority over start.
- row_limit  input  MEM_ADDRESS_LENGTH  last row index scanned (inclusive).
- col_limit  input  MEM_ADDRESS_LENGTH  last column index scanned (inclusive).
- row_col_cfg  input  1  value driven onto row_col_select for the whole scan.
- pulse_width  input  TIMER_BITS  drive pulse length in cycles; 0 is treated as 1.
- gap_width  input  TIMER_BITS  dead time after each pulse in cycles; 0 means no gap.
- firing_bit  input  1  from the dot sequencer: dot at current row/col is enabled.
- firing_data  input  1  from the dot sequencer: polarity for the current dot.
- row_select  output  MEM_ADDRESS_LENGTH  to the sequencer, registered.
- col_select  output  MEM_ADDRESS_LENGTH  to the sequencer, registered.
- row_col_select  output  1  to the sequencer, registered.
- drive_en  output  1  motor drive enable, registered.
- drive_pol  output  1  motor drive polarity, registered; valid while drive_en=1.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal scan completion.

Behaviour:
- Reset: state=IDLE. All outputs 0, including the row/col indices. Timers and latched config are cleared.
- Config latch: on an accepted start, latch row_limit, col_limit, row_col_cfg, pulse_width and gap_width. Later changes to these inputs have no effect until the next start.
- FSM states:
  - IDLE
    - busy=0 and drive_en=0.
    - start && !stop: row=0, col=0, row_col_select=row_col_cfg, go to SETTLE.
  - SETTLE: exactly 1 cycle with the indices stable.
    - At the clock edge, sample firing_bit and firing_data.
    - firing_bit=1: go to FIRE; load timer with max(pulse_width,1); drive_en<=1; drive_pol<=firing_data.
    - firing_bit=0: go to ADVANCE.
  - FIRE
    - drive_en held high for exactly max(pulse_width,1) cycles; timer decrements each cycle.
    - On expiry: drive_en<=0. If gap_width!=0, load the timer and go to GAP; otherwise go to ADVANCE.
  - GAP: drive_en=0 for exactly gap_width cycles, then go to ADVANCE.
  - ADVANCE: 1 cycle.
    - If col<col_limit: col++.
    - Else if row<row_limit: col=0, row++.
    - Else go to DONE.
    - In the first two cases, return to SETTLE.
  - DONE: done=1 for one cycle, busy=0, indices return to 0, go to IDLE.
- Latency:
  - Start accepted at edge N: SETTLE is the cycle after edge N.
  - A firing first dot gives drive_en=1 beginning the cycle after edge N+1.
  - Per-dot cost: non-firing dot = 2 cycles; firing dot = 2 + max(pw,1) + gw cycles.
- Limits: if row_limit or col_limit ≥ MEM_LENGTH, it is clamped to MEM_LENGTH-1 at latch time. Indices never exceed MEM_LENGTH-1, so there is no wrap-around past the matrix.
- Stop, in any non-IDLE state: next cycle state=IDLE and drive_en=0, even mid-pulse. busy=0, done stays 0, indices return to 0. Stop in IDLE is a no-op. Start and stop in the same cycle means stop wins and the start is discarded.
- Start while busy: ignored with no side effects.
- Reset during a scan: identical to the reset values above on the next cycle; no done pulse.
- The firing_bit/firing_data inputs are combinational from the sequencer and are sampled only in SETTLE.

Test Plan:
- Reset then idle: hold reset 2 cycles → all outputs 0, busy=0. Start with stop=1 → nothing happens.
- 2x2 scan, all dots firing_bit=1, data=1, pw=3, gw=2 → four drive_en bursts of exactly 3 cycles separated by 2+2 idle cycles (gap, advance, settle). Index order (0,0),(0,1),(1,0),(1,1); done pulses once; total busy = 4×7 cycles.
- 1x3 scan, firing_bit pattern 0,1,0, data=0, pw=0, gw=0 → a single 1-cycle drive_en with drive_pol=0 at (0,1). Non-firing dots take 2 cycles each; done asserted.
- Stop asserted on the 2nd cycle of a pw=5 pulse → drive_en low the next cycle, busy=0, done never asserted, indices 0. A subsequent start scans from (0,0).
- Change pulse_width from 4 to 9 mid-scan and assert start while busy → pulses stay 4 cycles and the scan is not restarted.
- row_limit=col_limit=63 with MEM_LENGTH=48 → indices reach (47,47) and never exceed it; done after 48×48 dots.

Source files
------------

// File: rtl/dot_scan_controller_if.sv
// Host/sequencer-facing signal bundle of the dot scan controller.
// The master side supplies control, configuration and the sequencer's firing inputs.
interface dot_scan_controller_if #(
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int TIMER_BITS         = 16
);
    logic                          start;
    logic                          stop;
    logic [MEM_ADDRESS_LENGTH-1:0] row_limit;
    logic [MEM_ADDRESS_LENGTH-1:0] col_limit;
    logic                          row_col_cfg;
    logic [TIMER_BITS-1:0]         pulse_width;
    logic [TIMER_BITS-1:0]         gap_width;
    logic                          firing_bit;
    logic                          firing_data;
    logic [MEM_ADDRESS_LENGTH-1:0] row_select;
    logic [MEM_ADDRESS_LENGTH-1:0] col_select;
    logic                          row_col_select;
    logic                          drive_en;
    logic                          drive_pol;
    logic                          busy;
    logic                          done;

    modport master (
        output start, stop, row_limit, col_limit, row_col_cfg,
               pulse_width, gap_width, firing_bit, firing_data,
        input  row_select, col_select, row_col_select,
               drive_en, drive_pol, busy, done
    );

    modport slave (
        input  start, stop, row_limit, col_limit, row_col_cfg,
               pulse_width, gap_width, firing_bit, firing_data,
        output row_select, col_select, row_col_select,
               drive_en, drive_pol, busy, done
    );
endinterface

// File: rtl/dot_scan_controller.sv
// Scan engine: walks a latched row/col rectangle, samples the dot sequencer in SETTLE,
// and turns each enabled dot into a timed drive pulse plus optional dead-time gap.
module dot_scan_controller #(
    parameter int MEM_LENGTH         = 48,
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int TIMER_BITS         = 16
) (
    input logic                  clock,
    input logic                  reset,
    dot_scan_controller_if.slave bus
);
    localparam logic [MEM_ADDRESS_LENGTH-1:0] LAST_INDEX = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);
    localparam logic [MEM_ADDRESS_LENGTH-1:0] ADDR_ONE   = MEM_ADDRESS_LENGTH'(1);
    localparam logic [TIMER_BITS-1:0]         TIMER_ONE  = TIMER_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FIRE,
        S_GAP,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t                        state;
    logic [TIMER_BITS-1:0]         timer;
    logic [MEM_ADDRESS_LENGTH-1:0] row_lim_q;
    logic [MEM_ADDRESS_LENGTH-1:0] col_lim_q;
    logic [TIMER_BITS-1:0]         pulse_q;
    logic [TIMER_BITS-1:0]         gap_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_IDLE;
            timer              <= '0;
            row_lim_q          <= '0;
            col_lim_q          <= '0;
            pulse_q            <= '0;
            gap_q              <= '0;
            bus.row_select     <= '0;
            bus.col_select     <= '0;
            bus.row_col_select <= 1'b0;
            bus.drive_en       <= 1'b0;
            bus.drive_pol      <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
        end else if (bus.stop && state != S_IDLE) begin
            // Abort cuts the pulse immediately; no done pulse is issued.
            state              <= S_IDLE;
            timer              <= '0;
            bus.row_select     <= '0;
            bus.col_select     <= '0;
            bus.row_col_select <= 1'b0;
            bus.drive_en       <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        row_lim_q          <= (bus.row_limit > LAST_INDEX) ? LAST_INDEX : bus.row_limit;
                        col_lim_q          <= (bus.col_limit > LAST_INDEX) ? LAST_INDEX : bus.col_limit;
                        pulse_q            <= (bus.pulse_width == '0) ? TIMER_ONE : bus.pulse_width;
                        gap_q              <= bus.gap_width;
                        bus.row_select     <= '0;
                        bus.col_select     <= '0;
                        bus.row_col_select <= bus.row_col_cfg;
                        bus.busy           <= 1'b1;
                        state              <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.firing_bit) begin
                        timer         <= pulse_q;
                        bus.drive_en  <= 1'b1;
                        bus.drive_pol <= bus.firing_data;
                        state         <= S_FIRE;
                    end else begin
                        state <= S_ADVANCE;
                    end
                end
                S_FIRE: begin
                    timer <= timer - TIMER_ONE;
                    if (timer == TIMER_ONE) begin
                        bus.drive_en <= 1'b0;
                        if (gap_q != '0) begin
                            timer <= gap_q;
                            state <= S_GAP;
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end
                end
                S_GAP: begin
                    timer <= timer - TIMER_ONE;
                    if (timer == TIMER_ONE) begin
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (bus.col_select < col_lim_q) begin
                        bus.col_select <= bus.col_select + ADDR_ONE;
                        state          <= S_SETTLE;
                    end else if (bus.row_select < row_lim_q) begin
                        bus.col_select <= '0;
                        bus.row_select <= bus.row_select + ADDR_ONE;
                        state          <= S_SETTLE;
                    end else begin
                        bus.row_select     <= '0;
                        bus.col_select     <= '0;
                        bus.row_col_select <= 1'b0;
                        bus.busy           <= 1'b0;
                        bus.done           <= 1'b1;
                        state              <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_scan_controller.sv
// Directed bench for dot_scan_controller; expected timelines are hand-derived per sample cycle.
module tb_dot_scan_controller;
    localparam int AW = 6;
    localparam int TB = 16;
    localparam int ML = 48;

    logic        clock = 1'b0;
    logic        reset;
    int          vectors = 0;
    int          miscompares = 0;
    logic        fire_all;
    logic [63:0] fire_cols;

    dot_scan_controller_if #(.MEM_ADDRESS_LENGTH(AW), .TIMER_BITS(TB)) bus ();

    dot_scan_controller #(
        .MEM_LENGTH(ML),
        .MEM_ADDRESS_LENGTH(AW),
        .TIMER_BITS(TB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    // Sequencer stand-in: firing_bit is combinational from the current column.
    assign bus.firing_bit = fire_all | fire_cols[bus.col_select];

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " drive_en"}, 32'(bus.drive_en), 32'd0);
        check({tag, " busy"},     32'(bus.busy),     32'd0);
        check({tag, " done"},     32'(bus.done),     32'd0);
        check({tag, " row"},      32'(bus.row_select), 32'd0);
        check({tag, " col"},      32'(bus.col_select), 32'd0);
    endtask

    task automatic start_scan(input logic [AW-1:0] rl, input logic [AW-1:0] cl, input logic cfg,
                              input logic [TB-1:0] pw, input logic [TB-1:0] gw);
        bus.row_limit   = rl;
        bus.col_limit   = cl;
        bus.row_col_cfg = cfg;
        bus.pulse_width = pw;
        bus.gap_width   = gw;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    initial begin
        int maxr;
        int maxc;
        int done_at;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.row_limit   = '0;
        bus.col_limit   = '0;
        bus.row_col_cfg = 1'b0;
        bus.pulse_width = '0;
        bus.gap_width   = '0;
        bus.firing_data = 1'b0;
        fire_all        = 1'b0;
        fire_cols       = '0;

        // Reset, then start together with stop must be discarded
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");
        check("reset drive_pol", 32'(bus.drive_pol), 32'd0);
        check("reset rcs", 32'(bus.row_col_select), 32'd0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("start+stop");
        tick();
        check("start+stop later busy", 32'(bus.busy), 32'd0);

        // 2x2, every dot fires, pw=3 gw=2: 7 cycles per dot
        fire_all        = 1'b1;
        bus.firing_data = 1'b1;
        start_scan(6'd1, 6'd1, 1'b1, 16'd3, 16'd2);
        for (int j = 1; j <= 28; j++) begin
            int p;
            int k;
            p = (j - 1) % 7;
            k = (j - 1) / 7;
            check($sformatf("2x2 drive_en j%0d", j), 32'(bus.drive_en), 32'((p >= 1) && (p <= 3)));
            check($sformatf("2x2 busy j%0d", j), 32'(bus.busy), 32'd1);
            check($sformatf("2x2 done j%0d", j), 32'(bus.done), 32'd0);
            if (p == 1) begin
                check($sformatf("2x2 pol j%0d", j), 32'(bus.drive_pol), 32'd1);
                check($sformatf("2x2 row j%0d", j), 32'(bus.row_select), 32'(k / 2));
                check($sformatf("2x2 col j%0d", j), 32'(bus.col_select), 32'(k % 2));
                check($sformatf("2x2 rcs j%0d", j), 32'(bus.row_col_select), 32'd1);
            end
            tick();
        end
        check("2x2 done pulse", 32'(bus.done), 32'd1);
        check("2x2 done busy", 32'(bus.busy), 32'd0);
        check("2x2 done row", 32'(bus.row_select), 32'd0);
        check("2x2 done col", 32'(bus.col_select), 32'd0);
        tick();
        check("2x2 done clears", 32'(bus.done), 32'd0);

        // 1x3, pattern 0,1,0, data=0, pw=0 gw=0
        fire_all        = 1'b0;
        fire_cols       = 64'h2;
        bus.firing_data = 1'b0;
        start_scan(6'd0, 6'd2, 1'b0, 16'd0, 16'd0);
        for (int j = 1; j <= 8; j++) begin
            check($sformatf("1x3 drive_en j%0d", j), 32'(bus.drive_en), 32'(j == 4));
            check($sformatf("1x3 busy j%0d", j), 32'(bus.busy), 32'(j <= 7));
            check($sformatf("1x3 done j%0d", j), 32'(bus.done), 32'(j == 8));
            if (j == 4) begin
                check("1x3 pol", 32'(bus.drive_pol), 32'd0);
                check("1x3 row", 32'(bus.row_select), 32'd0);
                check("1x3 col", 32'(bus.col_select), 32'd1);
            end
            tick();
        end
        check("1x3 done clears", 32'(bus.done), 32'd0);

        // Stop on the 2nd cycle of a pw=5 pulse at (0,1)
        bus.firing_data = 1'b1;
        fire_cols       = 64'h2;
        start_scan(6'd0, 6'd1, 1'b0, 16'd5, 16'd0);
        tick();
        tick();
        tick();
        check("stop pulse c1", 32'(bus.drive_en), 32'd1);
        check("stop pulse col", 32'(bus.col_select), 32'd1);
        tick();
        check("stop pulse c2", 32'(bus.drive_en), 32'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("after stop");
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("after stop done %0d", j), 32'(bus.done), 32'd0);
            check($sformatf("after stop busy %0d", j), 32'(bus.busy), 32'd0);
        end
        fire_cols = '0;
        start_scan(6'd0, 6'd1, 1'b0, 16'd5, 16'd0);
        check("restart busy", 32'(bus.busy), 32'd1);
        check("restart row", 32'(bus.row_select), 32'd0);
        check("restart col", 32'(bus.col_select), 32'd0);
        tick();
        tick();
        tick();
        tick();
        check("restart done", 32'(bus.done), 32'd1);
        tick();

        // pw=4 latched; pulse_width->9 and start while busy are both ignored
        fire_all = 1'b1;
        start_scan(6'd0, 6'd1, 1'b0, 16'd4, 16'd0);
        for (int j = 1; j <= 13; j++) begin
            check($sformatf("latch drive_en j%0d", j), 32'(bus.drive_en),
                  32'(((j >= 2) && (j <= 5)) || ((j >= 8) && (j <= 11))));
            check($sformatf("latch busy j%0d", j), 32'(bus.busy), 32'(j <= 12));
            check($sformatf("latch done j%0d", j), 32'(bus.done), 32'(j == 13));
            if (j == 7) check("latch col", 32'(bus.col_select), 32'd1);
            if (j == 2) bus.pulse_width = 16'd9;
            bus.start = (j == 3);
            tick();
        end
        bus.start = 1'b0;
        check("latch idle busy", 32'(bus.busy), 32'd0);

        // Limits of 63 clamp to 47: 48x48 non-firing dots, 2 cycles each
        fire_all = 1'b0;
        maxr     = 0;
        maxc     = 0;
        done_at  = 0;
        start_scan(6'd63, 6'd63, 1'b0, 16'd1, 16'd0);
        for (int j = 1; j <= 6000 && done_at == 0; j++) begin
            if (int'(bus.row_select) > maxr) maxr = int'(bus.row_select);
            if (int'(bus.col_select) > maxc) maxc = int'(bus.col_select);
            if (j == 4607) begin
                check("clamp last row", 32'(bus.row_select), 32'd47);
                check("clamp last col", 32'(bus.col_select), 32'd47);
            end
            if (bus.done) done_at = j;
            else tick();
        end
        check("clamp max row", 32'(maxr), 32'd47);
        check("clamp max col", 32'(maxc), 32'd47);
        check("clamp done cycle", 32'(done_at), 32'd4609);
        tick();

        // Reset mid-pulse returns everything to reset values with no done
        fire_all = 1'b1;
        start_scan(6'd1, 6'd1, 1'b1, 16'd5, 16'd0);
        tick();
        check("midreset pulse", 32'(bus.drive_en), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midreset");
        check("midreset pol", 32'(bus.drive_pol), 32'd0);
        check("midreset rcs", 32'(bus.row_col_select), 32'd0);
        tick();
        check("midreset no done", 32'(bus.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
